dac_data_odelay_tx: RTL and testbench

Transmit-side counterpart of the ADC input-delay path. It takes parallel samples through a valid/ready handshake and drives registered data to the DAC output pins. It also sequences per-lane tap values into the external loadable output-delay primitives (VAR_LOADABLE), one lane per cycle. It sits between the DDC output datapath and the DAC pin buffers, and provides a fixed alternating training pattern for DAC-side alignment.

---
 rtl/dac_tx_pkg.sv | 17 +
 rtl/dac_data_odelay_tx_if.sv | 11 +
 rtl/dac_tap_loader.sv | 100 ++++++++++
 rtl/dac_data_odelay_tx.sv | 64 ++++++
 tb/tb_dac_data_odelay_tx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_tx_pkg.sv
// Shared types and defaults for the DAC transmit path with loadable output delays.
package dac_tx_pkg;

   typedef enum logic [1:0] {ARM, LOAD, SETTLE, RUN} tx_state_t;

   localparam int DEF_DAC_DATA_WIDTH = 8;
   localparam int DEF_TAP_WIDTH      = 5;
   localparam int DEF_SETTLE_CYCLES  = 16;
   localparam logic [7:0] DEF_IDLE_CODE     = 8'h80;
   localparam logic [7:0] DEF_TRAIN_PATTERN = 8'h55;

   // Bit offset of a lane's tap field inside the packed tap configuration word.
   function automatic int lane_lsb(input int lane, input int tap_width);
      return lane * tap_width;
   endfunction

endpackage

// File: rtl/dac_data_odelay_tx_if.sv
// Sample stream handshake between the DDC output datapath and the DAC transmitter.
interface dac_data_odelay_tx_if #(
   parameter int DAC_DATA_WIDTH = 8
);
   logic [DAC_DATA_WIDTH-1:0] s_data;
   logic                      s_valid;
   logic                      s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_tap_loader.sv
// Sequences per-lane tap values into the output-delay primitives, one lane per cycle,
// then waits a settle period before releasing the datapath.
module dac_tap_loader
   import dac_tx_pkg::*;
#(
   parameter int DAC_DATA_WIDTH = DEF_DAC_DATA_WIDTH,
   parameter int TAP_WIDTH      = DEF_TAP_WIDTH,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [DAC_DATA_WIDTH*TAP_WIDTH-1:0] tap_cfg_in,
   input  logic                                tap_load_req,
   output tx_state_t                           state,
   output logic [TAP_WIDTH-1:0]                odly_cntvaluein,
   output logic [DAC_DATA_WIDTH-1:0]           odly_ld,
   output logic                                busy,
   output logic                                load_done
);

   localparam int CFG_W  = DAC_DATA_WIDTH * TAP_WIDTH;
   localparam int IDX_W  = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam int LANE_W = (DAC_DATA_WIDTH > 1) ? $clog2(DAC_DATA_WIDTH) : 1;
   localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [LANE_W-1:0]         LAST_LANE    = LANE_W'(DAC_DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0]          SETTLE_INIT  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [DAC_DATA_WIDTH-1:0] LANE0_STROBE = DAC_DATA_WIDTH'(1);

   logic [CFG_W-1:0]  shadow;
   logic [LANE_W-1:0] lane;
   logic [LANE_W-1:0] next_lane;
   logic [IDX_W-1:0]  next_lsb;
   logic [CNT_W-1:0]  settle_cnt;
   logic              pending;

   assign next_lane = lane + 1'b1;
   assign next_lsb  = IDX_W'(lane_lsb(int'(next_lane), TAP_WIDTH));

   // Strobe outputs are set one edge ahead so each lane's strobe lines up with
   // the LOAD cycle that owns it; lane 0 comes straight from the live taps in ARM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ARM;
         shadow          <= '0;
         lane            <= '0;
         settle_cnt      <= '0;
         pending         <= 1'b0;
         odly_ld         <= '0;
         odly_cntvaluein <= '0;
         busy            <= 1'b1;
         load_done       <= 1'b0;
      end else begin
         load_done <= 1'b0;
         case (state)
            ARM: begin
               shadow          <= tap_cfg_in;
               lane            <= '0;
               odly_ld         <= LANE0_STROBE;
               odly_cntvaluein <= tap_cfg_in[TAP_WIDTH-1:0];
               if (tap_load_req) pending <= 1'b1;
               state <= LOAD;
            end
            LOAD: begin
               if (tap_load_req) pending <= 1'b1;
               if (lane == LAST_LANE) begin
                  odly_ld         <= '0;
                  odly_cntvaluein <= '0;
                  settle_cnt      <= SETTLE_INIT;
                  state           <= SETTLE;
               end else begin
                  lane            <= next_lane;
                  odly_ld         <= LANE0_STROBE << next_lane;
                  odly_cntvaluein <= shadow[next_lsb +: TAP_WIDTH];
               end
            end
            SETTLE: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - 1'b1;
                  if (tap_load_req) pending <= 1'b1;
               end else if (pending || tap_load_req) begin
                  pending <= 1'b0;
                  state   <= ARM;
               end else begin
                  busy      <= 1'b0;
                  load_done <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (tap_load_req) begin
                  busy  <= 1'b1;
                  state <= ARM;
               end
            end
            default: state <= ARM;
         endcase
      end
   end

endmodule

// File: rtl/dac_data_odelay_tx.sv
// DAC transmit pin register with training-pattern generator; tap loading is
// delegated to dac_tap_loader and samples only flow while it reports RUN.
module dac_data_odelay_tx
   import dac_tx_pkg::*;
#(
   parameter int                        DAC_DATA_WIDTH = DEF_DAC_DATA_WIDTH,
   parameter int                        TAP_WIDTH      = DEF_TAP_WIDTH,
   parameter int                        SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter logic [DAC_DATA_WIDTH-1:0] IDLE_CODE      = DEF_IDLE_CODE,
   parameter logic [DAC_DATA_WIDTH-1:0] TRAIN_PATTERN  = DEF_TRAIN_PATTERN
) (
   input  logic                                dac_clk_bufr,
   input  logic                                rst_n,
   input  logic [DAC_DATA_WIDTH*TAP_WIDTH-1:0] tap_cfg_in,
   input  logic                                tap_load_req,
   input  logic                                train_en,
   dac_data_odelay_tx_if.slave                 s_if,
   output logic [DAC_DATA_WIDTH-1:0]           dac_data_o,
   output logic [TAP_WIDTH-1:0]                odly_cntvaluein,
   output logic [DAC_DATA_WIDTH-1:0]           odly_ld,
   output logic                                busy,
   output logic                                load_done
);

   tx_state_t ld_state;
   logic      train_phase;

   dac_tap_loader #(
      .DAC_DATA_WIDTH (DAC_DATA_WIDTH),
      .TAP_WIDTH      (TAP_WIDTH),
      .SETTLE_CYCLES  (SETTLE_CYCLES)
   ) u_loader (
      .clk             (dac_clk_bufr),
      .rst_n           (rst_n),
      .tap_cfg_in      (tap_cfg_in),
      .tap_load_req    (tap_load_req),
      .state           (ld_state),
      .odly_cntvaluein (odly_cntvaluein),
      .odly_ld         (odly_ld),
      .busy            (busy),
      .load_done       (load_done)
   );

   assign s_if.s_ready = (ld_state == RUN);

   // Training takes priority over samples; the phase restarts at TRAIN_PATTERN
   // whenever training is off or the link leaves RUN.
   always_ff @(posedge dac_clk_bufr or negedge rst_n) begin
      if (!rst_n) begin
         dac_data_o  <= IDLE_CODE;
         train_phase <= 1'b0;
      end else if (ld_state != RUN) begin
         dac_data_o  <= IDLE_CODE;
         train_phase <= 1'b0;
      end else if (train_en) begin
         dac_data_o  <= train_phase ? ~TRAIN_PATTERN : TRAIN_PATTERN;
         train_phase <= ~train_phase;
      end else begin
         train_phase <= 1'b0;
         if (s_if.s_valid) dac_data_o <= s_if.s_data;
      end
   end

endmodule

// File: tb/tb_dac_data_odelay_tx.sv
// Scoreboard bench for dac_data_odelay_tx: a load-sequence position model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_dac_data_odelay_tx;

   localparam int         W      = 8;
   localparam int         TW     = 5;
   localparam int         S      = 16;
   localparam int         LAST   = W + S;
   localparam logic [7:0] IDLE   = 8'h80;
   localparam logic [7:0] TP     = 8'h55;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] ld;
      logic [4:0] val;
      logic       rdy;
      logic       busy;
      logic       done;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [W-1:0][TW-1:0]  tap_cfg_in;
   logic                  tap_load_req;
   logic                  train_en;
   logic [7:0]            dac_data_o;
   logic [TW-1:0]         odly_cntvaluein;
   logic [W-1:0]          odly_ld;
   logic                  busy;
   logic                  load_done;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   dac_data_odelay_tx_if #(.DAC_DATA_WIDTH(W)) s_if ();

   dac_data_odelay_tx dut (
      .dac_clk_bufr    (clk),
      .rst_n           (rst_n),
      .tap_cfg_in      (tap_cfg_in),
      .tap_load_req    (tap_load_req),
      .train_en        (train_en),
      .s_if            (s_if),
      .dac_data_o      (dac_data_o),
      .odly_cntvaluein (odly_cntvaluein),
      .odly_ld         (odly_ld),
      .busy            (busy),
      .load_done       (load_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic train, input logic req);
      @(posedge clk);
      #1;
      s_if.s_valid = valid;
      s_if.s_data  = data;
      train_en     = train;
      tap_load_req = req;
   endtask

   task automatic waitReady(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!s_if.s_ready && n < limit);
      if (!s_if.s_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout s_ready=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_dac_data_o"}, 32'(dac_data_o), 32'(IDLE));
      checkOutput({tag, "_odly_ld"}, 32'(odly_ld), 32'h0);
      checkOutput({tag, "_odly_cntvaluein"}, 32'(odly_cntvaluein), 32'h0);
      checkOutput({tag, "_s_ready"}, 32'(s_if.s_ready), 32'h0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h1);
      checkOutput({tag, "_load_done"}, 32'(load_done), 32'h0);
   endtask

   // Reference model: position 0 is the capture cycle, 1..W strobe lanes 0..W-1,
   // W+1..W+S are settle cycles; running means samples flow.
   int         m_pos = 0;
   bit         m_run = 1'b0;
   bit         m_pend = 1'b0;
   bit         m_phase = 1'b0;
   bit         m_was_run;
   bit         m_done;
   logic [7:0] m_data = IDLE;
   int         m_taps[W];
   exp_t       m_e;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pos = 0; m_run = 1'b0; m_pend = 1'b0; m_phase = 1'b0; m_data = IDLE;
            exp_q.delete();
         end else begin
            m_was_run = m_run;
            m_done    = 1'b0;
            if (m_was_run) begin
               if (train_en) begin
                  m_data  = m_phase ? ~TP : TP;
                  m_phase = !m_phase;
               end else begin
                  m_phase = 1'b0;
                  if (s_if.s_valid) m_data = s_if.s_data;
               end
               if (tap_load_req) begin
                  m_run = 1'b0;
                  m_pos = 0;
               end
            end else begin
               m_data  = IDLE;
               m_phase = 1'b0;
               if (m_pos == 0)
                  for (int i = 0; i < W; i++) m_taps[3'(i)] = int'(tap_cfg_in[3'(i)]);
               if (m_pos == LAST) begin
                  if (m_pend || tap_load_req) begin
                     m_pend = 1'b0;
                     m_pos  = 0;
                  end else begin
                     m_run  = 1'b1;
                     m_done = 1'b1;
                  end
               end else begin
                  if (tap_load_req) m_pend = 1'b1;
                  m_pos++;
               end
            end
            m_e.data = m_data;
            m_e.ld   = (!m_run && m_pos >= 1 && m_pos <= W) ? 8'(1 << (m_pos - 1)) : 8'h0;
            m_e.val  = (!m_run && m_pos >= 1 && m_pos <= W) ? 5'(m_taps[3'(m_pos - 1)]) : 5'h0;
            m_e.rdy  = m_run;
            m_e.busy = !m_run;
            m_e.done = m_done;
            exp_q.push_back(m_e);
         end
      end
   end

   // Monitor: reset values while rst_n is low, otherwise the oldest prediction.
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            checkResetValues("mon_reset");
         end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("dac_data_o", 32'(dac_data_o), 32'(mon_e.data));
            checkOutput("odly_ld", 32'(odly_ld), 32'(mon_e.ld));
            checkOutput("odly_cntvaluein", 32'(odly_cntvaluein), 32'(mon_e.val));
            checkOutput("s_ready", 32'(s_if.s_ready), 32'(mon_e.rdy));
            checkOutput("busy", 32'(busy), 32'(mon_e.busy));
            checkOutput("load_done", 32'(load_done), 32'(mon_e.done));
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog simulation did not finish, expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      s_if.s_valid = 1'b0;
      s_if.s_data  = 8'h00;
      train_en     = 1'b0;
      tap_load_req = 1'b0;
      for (int i = 0; i < W; i++) tap_cfg_in[3'(i)] = 5'(i + 1);

      repeat (3) @(posedge clk);
      #2;
      checkResetValues("init_reset");
      rst_n = 1'b1;
      waitReady(60, n);
      checkOutput("ready_latency_after_reset", 32'(n), 32'd25);

      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 8'h99, 1'b0, 1'b0);

      repeat (4) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) tap_cfg_in[3'(i)] = 5'h1F;
      waitReady(100, n);
      checkOutput("ready_latency_reload", 32'(n), 32'd24);

      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (12) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      waitReady(200, n);
      checkOutput("ready_latency_double_req", 32'(n), 32'd35);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 19) == 0) tap_cfg_in = 40'({$urandom(), $urandom()});
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                       ($urandom_range(0, 3) == 0) ? !train_en : train_en,
                       $urandom_range(0, 59) == 0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      waitReady(200, n);

      for (int i = 0; i < W; i++) tap_cfg_in[3'(i)] = 5'(2 * i + 3);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("odly_ld_fourth_lane", 32'(odly_ld), 32'h08);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetValues("async_reset");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      waitReady(60, n);
      checkOutput("ready_latency_after_abort", 32'(n), 32'd25);

      repeat (3) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
